dot_accumulator: RTL and testbench

- Downstream stage of the multiplier: drains the product FIFO that the multiplier fills, one 32-bit product per pop.
- Sums each group of vec_len consecutive products into one dot-product element, i.e. one entry of the result matrix.
- Writes each finished element to the result register file / memory with an incrementing address.
- Controlled by the same opstart/opclear/opdone protocol as the multiplier.

---
 rtl/dot_accumulator_pkg.sv | 12 +
 rtl/dot_accumulator_if.sv | 29 ++
 rtl/dot_accumulator_acc_datapath.sv | 63 ++++++
 rtl/dot_accumulator.sv | 115 +++++++++++
 tb/tb_dot_accumulator.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dot_accumulator_pkg.sv
// Shared widths and FSM encoding for the dot-product accumulator.
package dot_accumulator_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } acc_state_e;
endpackage

// File: rtl/dot_accumulator_if.sv
// Control, product-FIFO and result-write signals of the accumulator.
interface dot_accumulator_if;
  import dot_accumulator_pkg::*;

  logic              acc_opstart;
  logic              acc_opclear;
  logic [2:0]        vec_len;
  logic [4:0]        num_results;
  logic [CNT_W-1:0]  fifo_data_count;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_re;
  logic              res_we;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_data;
  logic              acc_busy;
  logic              acc_opdone;

  // controller / FIFO side
  modport master (
    output acc_opstart, acc_opclear, vec_len, num_results, fifo_data_count, fifo_dout,
    input  fifo_re, res_we, res_addr, res_data, acc_busy, acc_opdone
  );

  // accumulator side
  modport slave (
    input  acc_opstart, acc_opclear, vec_len, num_results, fifo_data_count, fifo_dout,
    output fifo_re, res_we, res_addr, res_data, acc_busy, acc_opdone
  );
endinterface

// File: rtl/dot_accumulator_acc_datapath.sv
// Accumulator register, adder and registered result-write port.
module acc_datapath
  import dot_accumulator_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              vld,
  input  logic              first,
  input  logic              last,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] idx,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_data
);
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              res_we_q, res_we_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [DATA_W-1:0] sum;

  // first product of an element starts from zero so no residue carries over
  always_comb begin
    sum        = (first ? '0 : acc_q) + din;
    acc_d      = acc_q;
    res_we_d   = 1'b0;
    res_addr_d = res_addr_q;
    res_data_d = res_data_q;
    if (clr) begin
      acc_d      = '0;
      res_addr_d = '0;
      res_data_d = '0;
    end else if (vld) begin
      if (last) begin
        res_we_d   = 1'b1;
        res_data_d = sum;
        res_addr_d = idx;
      end else begin
        acc_d = sum;
      end
    end
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      res_we_q   <= 1'b0;
      res_addr_q <= '0;
      res_data_q <= '0;
    end else begin
      acc_q      <= acc_d;
      res_we_q   <= res_we_d;
      res_addr_q <= res_addr_d;
      res_data_q <= res_data_d;
    end
  end

  assign res_we   = res_we_q;
  assign res_addr = res_addr_q;
  assign res_data = res_data_q;
endmodule

// File: rtl/dot_accumulator.sv
// Drains the product FIFO, sums vec_len products per element, writes results.
module dot_accumulator
  import dot_accumulator_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  dot_accumulator_if.slave bus
);
  acc_state_e  state_q, state_d;
  logic [2:0]  vec_len_q, vec_len_d;
  logic [4:0]  num_res_q, num_res_d;
  logic [7:0]  reads_q, reads_d;
  logic [2:0]  elem_q, elem_d;
  logic [4:0]  res_idx_q, res_idx_d;
  logic        rd_pending_q, rd_pending_d;

  logic        fifo_re, first_el, last_el;
  logic [7:0]  total_reads;
  logic              dp_we;
  logic [ADDR_W-1:0] dp_addr;
  logic [DATA_W-1:0] dp_data;

  assign total_reads = 8'(vec_len_q) * 8'(num_res_q);
  assign first_el    = (elem_q == 3'd0);
  assign last_el     = (elem_q == vec_len_q - 3'd1);

  // next-state, read issue and counter updates; clear overrides everything
  always_comb begin
    state_d   = state_q;
    vec_len_d = vec_len_q;
    num_res_d = num_res_q;
    reads_d   = reads_q;
    elem_d    = elem_q;
    res_idx_d = res_idx_q;
    fifo_re   = 1'b0;
    case (state_q)
      IDLE: if (bus.acc_opstart) begin
        vec_len_d = bus.vec_len;
        num_res_d = bus.num_results;
        reads_d   = '0;
        elem_d    = '0;
        res_idx_d = '0;
        state_d   = (bus.vec_len == 3'd0 || bus.num_results == 5'd0) ? DONE : RUN;
      end
      RUN: begin
        // a pending pop may not be reflected in the count yet; never risk the last entry
        fifo_re = (reads_q < total_reads) && (bus.fifo_data_count != '0) &&
                  !(bus.fifo_data_count == CNT_W'(1) && rd_pending_q);
        if (fifo_re) reads_d = reads_q + 8'd1;
        if (rd_pending_q) begin
          if (last_el) begin
            elem_d    = '0;
            res_idx_d = res_idx_q + 5'd1;
          end else begin
            elem_d = elem_q + 3'd1;
          end
        end
        if (dp_we && ({1'b0, dp_addr} == num_res_q - 5'd1)) state_d = DONE;
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
    if (bus.acc_opclear) begin
      state_d   = IDLE;
      reads_d   = '0;
      elem_d    = '0;
      res_idx_d = '0;
      fifo_re   = 1'b0;
    end
    if (reset) fifo_re = 1'b0;
    rd_pending_d = fifo_re;
  end

  // control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      vec_len_q    <= '0;
      num_res_q    <= '0;
      reads_q      <= '0;
      elem_q       <= '0;
      res_idx_q    <= '0;
      rd_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_len_q    <= vec_len_d;
      num_res_q    <= num_res_d;
      reads_q      <= reads_d;
      elem_q       <= elem_d;
      res_idx_q    <= res_idx_d;
      rd_pending_q <= rd_pending_d;
    end
  end

  acc_datapath u_dp (
    .clk      (clk),
    .reset    (reset),
    .clr      (bus.acc_opclear),
    .vld      (rd_pending_q),
    .first    (first_el),
    .last     (last_el),
    .din      (bus.fifo_dout),
    .idx      (res_idx_q[ADDR_W-1:0]),
    .res_we   (dp_we),
    .res_addr (dp_addr),
    .res_data (dp_data)
  );

  assign bus.fifo_re    = fifo_re;
  assign bus.res_we     = dp_we;
  assign bus.res_addr   = dp_addr;
  assign bus.res_data   = dp_data;
  assign bus.acc_busy   = (state_q == RUN);
  assign bus.acc_opdone = (state_q == DONE);
endmodule

// File: tb/tb_dot_accumulator.sv
// Scoreboard bench: a FIFO model feeds products, a monitor checks every result write.
module tb_dot_accumulator;
  import dot_accumulator_pkg::*;

  logic clk = 1'b0;
  logic reset;
  dot_accumulator_if bus();

  dot_accumulator dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_we_cyc = -10;
  logic re_seen = 1'b0;

  // stimulus-owned push log and expected-result log; consumers keep read pointers
  logic [31:0] push_mem [0:8191];
  int          push_cnt = 0;
  int          push_taken = 0;
  int          flush_tok = 0;
  int          flush_done = 0;
  logic [31:0] fifo_q [$];
  logic [ADDR_W-1:0] exp_addr [0:2047];
  logic [DATA_W-1:0] exp_data [0:2047];
  int          exp_wr = 0;
  int          exp_rd = 0;
  logic [31:0] job_p [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // synchronous FIFO model: data appears the cycle after a pop
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    re_seen <= bus.fifo_re;
    if (flush_tok != flush_done) begin
      fifo_q.delete();
      push_taken = push_cnt;
      flush_done = flush_tok;
    end else begin
      if (bus.fifo_re) begin
        checks++;
        if (fifo_q.size() == 0) begin
          errors++;
          $display("FAIL underflow: pop with fifo size 0 (cycle %0d)", cyc);
        end else begin
          bus.fifo_dout <= fifo_q.pop_front();
        end
      end
      while (push_taken < push_cnt && fifo_q.size() < 15) begin
        fifo_q.push_back(push_mem[push_taken]);
        push_taken++;
      end
    end
    bus.fifo_data_count <= CNT_W'(fifo_q.size());
  end

  // monitor: scoreboard pop on each write, plus the read-guard rule
  always @(negedge clk) begin
    if (bus.res_we) begin
      if (exp_rd >= exp_wr) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we: addr %0h data %0h, nothing expected", bus.res_addr, bus.res_data);
      end else begin
        chk("res_addr", 32'(bus.res_addr), 32'(exp_addr[exp_rd]));
        chk("res_data", bus.res_data, exp_data[exp_rd]);
        exp_rd++;
      end
      last_we_cyc = cyc;
    end
    if (bus.acc_busy && bus.fifo_data_count <= CNT_W'(1)) begin
      checks++;
      if (bus.fifo_re && (bus.fifo_data_count == '0 || re_seen)) begin
        errors++;
        $display("FAIL read_guard: fifo_re=1 count=%0d rd_pending=%0b", bus.fifo_data_count, re_seen);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [31:0] v);
    push_mem[push_cnt] = v;
    push_cnt++;
  endtask

  task automatic flush();
    flush_tok++;
    tick(2);
  endtask

  task automatic start(input int vl, input int nr);
    bus.vec_len     = 3'(vl);
    bus.num_results = 5'(nr);
    bus.acc_opstart = 1'b1;
    tick(1);
    bus.acc_opstart = 1'b0;
  endtask

  task automatic clear_op();
    bus.acc_opclear = 1'b1;
    tick(1);
    bus.acc_opclear = 1'b0;
    chk("clr_busy", 32'(bus.acc_busy), 0);
    chk("clr_done", 32'(bus.acc_opdone), 0);
    chk("clr_data", bus.res_data, 0);
  endtask

  task automatic wait_done(input bool_writes);
    int n = 0;
    while (!bus.acc_opdone && n < 3000) begin
      tick(1);
      n++;
    end
    chk("done_timeout", 32'(bus.acc_opdone), 1);
    if (bool_writes != 0) chk("done_latency", 32'(cyc), 32'(last_we_cyc + 1));
  endtask

  // kind: 0 random, 1 all ones, 2 taken from job_p
  task automatic run_job(input int vl, input int nr, input int gap, input int kind);
    logic [31:0] ev [4];
    logic [31:0] s;
    logic [31:0] last_s = 0;
    start(vl, nr);
    for (int e = 0; e < nr; e++) begin
      s = 0;
      for (int i = 0; i < vl; i++) begin
        if (kind == 0)      ev[i] = $urandom;
        else if (kind == 1) ev[i] = 32'd1;
        else                ev[i] = job_p.pop_front();
        s = s + ev[i];
      end
      exp_addr[exp_wr] = ADDR_W'(e);
      exp_data[exp_wr] = s;
      exp_wr++;
      last_s = s;
      for (int i = 0; i < vl; i++) begin
        push(ev[i]);
        if (gap > 0) tick(gap);
      end
    end
    wait_done(1);
    chk("all_written", 32'(exp_rd), 32'(exp_wr));
    chk("hold_addr", 32'(bus.res_addr), 32'(nr - 1));
    chk("hold_data", bus.res_data, last_s);
    tick(2);
    chk("done_held", 32'(bus.acc_opdone), 1);
    clear_op();
    tick(1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"},   32'(bus.res_we), 0);
    chk({tag, "_addr"}, 32'(bus.res_addr), 0);
    chk({tag, "_data"}, bus.res_data, 0);
    chk({tag, "_busy"}, 32'(bus.acc_busy), 0);
    chk({tag, "_done"}, 32'(bus.acc_opdone), 0);
    chk({tag, "_re"},   32'(bus.fifo_re), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.acc_opstart = 1'b0;
    bus.acc_opclear = 1'b0;
    bus.vec_len     = 3'd0;
    bus.num_results = 5'd0;
    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    tick(2);

    // basic element
    job_p = '{32'd3, 32'd5};
    run_job(2, 1, 0, 2);

    // full 4x4 of ones
    run_job(4, 16, 0, 1);

    // trickle: one product per three cycles keeps the count at 0/1
    run_job(3, 3, 3, 0);

    // wrap-around
    job_p = '{32'hFFFF_FFFF, 32'h0000_0002};
    run_job(2, 1, 0, 2);

    // zero-length jobs go straight to DONE without popping
    push(32'd7);
    tick(2);
    start(0, 5);
    wait_done(0);
    chk("zero_vl_nopop", 32'(bus.fifo_data_count), 1);
    clear_op();
    start(3, 0);
    wait_done(0);
    chk("zero_nr_nopop", 32'(bus.fifo_data_count), 1);
    clear_op();
    flush();

    // clear and start together mid-element
    start(4, 2);
    push(32'd100);
    tick(4);
    bus.vec_len     = 3'd1;
    bus.num_results = 5'd1;
    bus.acc_opstart = 1'b1;
    bus.acc_opclear = 1'b1;
    tick(1);
    bus.acc_opstart = 1'b0;
    bus.acc_opclear = 1'b0;
    chk("cs_busy", 32'(bus.acc_busy), 0);
    chk("cs_done", 32'(bus.acc_opdone), 0);
    tick(3);
    chk("cs_idle", 32'(bus.acc_busy), 0);
    flush();
    run_job(4, 2, 0, 0);

    // reset mid-run with a start held alongside it
    start(2, 4);
    push(32'd9);
    tick(4);
    reset           = 1'b1;
    bus.acc_opstart = 1'b1;
    tick(1);
    reset           = 1'b0;
    bus.acc_opstart = 1'b0;
    check_all_zero("rst_run");
    tick(2);
    chk("rst_idle", 32'(bus.acc_busy), 0);
    flush();

    // randomized jobs
    for (int j = 0; j < 6; j++)
      run_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 16)), int'($urandom_range(0, 2)), 0);

    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
